// File: rtl/mimo_pkg.sv
// -----------------------------------------------------------------------------
// mimo_pkg
// Shared constants and types for the MIMO frame loader.
//   NUM_ANT     : default antenna count (H is NUM_ANT x NUM_ANT)
//   DATA_W      : default word width (IEEE-754 single bit patterns)
//   FRAME_WORDS : words per frame = H (row-major) + received vector + SNR
//   wr_state_t  : input-side write FSM states
// -----------------------------------------------------------------------------
package mimo_pkg;

   localparam int NUM_ANT     = 4;
   localparam int DATA_W      = 32;
   localparam int FRAME_WORDS = NUM_ANT * NUM_ANT + NUM_ANT + 1;

   typedef enum logic {
      ST_FILL    = 1'b0,
      ST_DISCARD = 1'b1
   } wr_state_t;

endpackage

// File: rtl/frame_bank.sv
// -----------------------------------------------------------------------------
// frame_bank
// Storage for one complete frame: indexed write port, whole-frame read-out.
// Contents clear to zero on reset so the loader's outputs read zero afterwards.
// Ports:
//   clk, reset : clock and synchronous active-high reset
//   we         : write enable
//   waddr      : word index within the frame
//   wdata      : word to store
//   rdata      : all stored words, index 0 = first word of the frame
// -----------------------------------------------------------------------------
module frame_bank #(
   parameter  int DATA_W = mimo_pkg::DATA_W,
   parameter  int WORDS  = mimo_pkg::FRAME_WORDS,
   localparam int AW     = $clog2(WORDS)
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          we,
   input  logic [AW-1:0]                 waddr,
   input  logic [DATA_W-1:0]             wdata,
   output logic [WORDS-1:0][DATA_W-1:0]  rdata
);
   import mimo_pkg::*;

   logic [WORDS-1:0][DATA_W-1:0] r_mem;

   always_ff @(posedge clk) begin
      for (int i = 0; i < WORDS; i++) begin
         if (reset) begin
            r_mem[i] <= '0;
         end else if (we && (waddr == AW'(i))) begin
            r_mem[i] <= wdata;
         end
      end
   end

   assign rdata = r_mem;

endmodule

// File: rtl/mimo_frame_loader.sv
// -----------------------------------------------------------------------------
// mimo_frame_loader
// Collects a word stream into complete frames (H row-major, received vector,
// SNR) using two ping-pong banks and presents the oldest complete frame.
// Malformed frames (early or missing in_last) are dropped with an err_len pulse.
// Ports:
//   clk, reset              : clock, synchronous active-high reset
//   in_valid/in_ready       : input word handshake
//   in_data, in_last        : stream word, end-of-frame marker
//   out_valid/out_ready     : frame presentation handshake (release)
//   H_matrix, signal_receive, snr : fields of the presented frame
//   err_len                 : one-cycle pulse for a dropped malformed frame
//   frame_cnt               : number of frames released (wraps)
// -----------------------------------------------------------------------------
module mimo_frame_loader #(
   parameter int NUM_ANT = mimo_pkg::NUM_ANT,
   parameter int DATA_W  = mimo_pkg::DATA_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_last,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] H_matrix [0:NUM_ANT-1][0:NUM_ANT-1],
   output logic [DATA_W-1:0] signal_receive [0:NUM_ANT-1],
   output logic [DATA_W-1:0] snr,
   output logic              err_len,
   output logic [15:0]       frame_cnt
);
   import mimo_pkg::*;

   localparam int WORDS = NUM_ANT * NUM_ANT + NUM_ANT + 1;
   localparam int CW    = $clog2(WORDS);

   wr_state_t        r_state;
   logic [CW-1:0]    r_cnt;
   logic [1:0]       r_full;
   logic             r_wr_ptr;
   logic             r_rd_ptr;
   logic             r_out_valid;
   logic             r_err_len;
   logic [15:0]      r_frame_cnt;

   logic             w_xfer;
   logic             w_fill;
   logic             w_last_pos;
   logic             w_complete;
   logic             w_release;
   logic [1:0]       w_full_nxt;
   logic             w_rd_nxt;
   logic             w_we0;
   logic             w_we1;
   logic [WORDS-1:0][DATA_W-1:0] w_bank0;
   logic [WORDS-1:0][DATA_W-1:0] w_bank1;
   logic [WORDS-1:0][DATA_W-1:0] w_rd_words;

   // Only a FILL into a still-occupied bank has to wait; DISCARD always drains.
   assign in_ready   = ~reset & ~(w_fill & r_full[r_wr_ptr]);
   assign w_fill     = (r_state == ST_FILL);
   assign w_xfer     = in_valid & in_ready;
   assign w_last_pos = (r_cnt == CW'(WORDS - 1));
   assign w_complete = w_xfer & w_fill & w_last_pos & in_last;
   assign w_release  = r_out_valid & out_ready;
   assign w_we0      = w_xfer & w_fill & ~r_wr_ptr;
   assign w_we1      = w_xfer & w_fill &  r_wr_ptr;

   // Completion and release always target different banks (the write bank is
   // empty when accepting, the read bank is full when releasing), so both
   // updates can apply in the same cycle.
   always_comb begin
      w_full_nxt = r_full;
      if (w_complete) w_full_nxt[r_wr_ptr] = 1'b1;
      if (w_release)  w_full_nxt[r_rd_ptr] = 1'b0;
   end

   assign w_rd_nxt = r_rd_ptr ^ w_release;

   frame_bank #(.DATA_W(DATA_W), .WORDS(WORDS)) u_bank0 (
      .clk   (clk),
      .reset (reset),
      .we    (w_we0),
      .waddr (r_cnt),
      .wdata (in_data),
      .rdata (w_bank0)
   );

   frame_bank #(.DATA_W(DATA_W), .WORDS(WORDS)) u_bank1 (
      .clk   (clk),
      .reset (reset),
      .we    (w_we1),
      .waddr (r_cnt),
      .wdata (in_data),
      .rdata (w_bank1)
   );

   assign w_rd_words = r_rd_ptr ? w_bank1 : w_bank0;

   always_comb begin
      for (int r = 0; r < NUM_ANT; r++) begin
         for (int c = 0; c < NUM_ANT; c++) begin
            H_matrix[r][c] = w_rd_words[r * NUM_ANT + c];
         end
      end
      for (int i = 0; i < NUM_ANT; i++) begin
         signal_receive[i] = w_rd_words[NUM_ANT * NUM_ANT + i];
      end
      snr = w_rd_words[WORDS - 1];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= ST_FILL;
         r_cnt       <= '0;
         r_full      <= '0;
         r_wr_ptr    <= 1'b0;
         r_rd_ptr    <= 1'b0;
         r_out_valid <= 1'b0;
         r_err_len   <= 1'b0;
         r_frame_cnt <= '0;
      end else begin
         r_err_len <= 1'b0;
         case (r_state)
            ST_FILL: begin
               if (w_xfer) begin
                  if (in_last) begin
                     r_cnt <= '0;
                     if (w_last_pos) r_wr_ptr  <= ~r_wr_ptr;
                     else            r_err_len <= 1'b1;
                  end else if (w_last_pos) begin
                     // Frame overran its length: drop it and skip to in_last.
                     r_err_len <= 1'b1;
                     r_cnt     <= '0;
                     r_state   <= ST_DISCARD;
                  end else begin
                     r_cnt <= r_cnt + 1'b1;
                  end
               end
            end
            ST_DISCARD: begin
               if (w_xfer && in_last) begin
                  r_state <= ST_FILL;
                  r_cnt   <= '0;
               end
            end
            default: r_state <= ST_FILL;
         endcase
         r_full      <= w_full_nxt;
         r_rd_ptr    <= w_rd_nxt;
         r_out_valid <= w_full_nxt[w_rd_nxt];
         if (w_release) r_frame_cnt <= r_frame_cnt + 16'd1;
      end
   end

   assign out_valid = r_out_valid;
   assign err_len   = r_err_len;
   assign frame_cnt = r_frame_cnt;

endmodule

// File: tb/tb_mimo_frame_loader.sv
// -----------------------------------------------------------------------------
// tb_mimo_frame_loader
// Self-checking bench: frame-level table vectors, hand sequences for
// back-pressure, simultaneous release/completion and mid-frame reset, and a
// randomized run against a queue-based frame model.
// -----------------------------------------------------------------------------
module tb_mimo_frame_loader;

   localparam int NA = 4;
   localparam int FW = NA * NA + NA + 1;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_data;
   logic        in_last;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] H_matrix [0:NA-1][0:NA-1];
   logic [31:0] signal_receive [0:NA-1];
   logic [31:0] snr;
   logic        err_len;
   logic [15:0] frame_cnt;

   mimo_frame_loader #(.NUM_ANT(NA), .DATA_W(32)) dut (
      .clk            (clk),
      .reset          (reset),
      .in_valid       (in_valid),
      .in_ready       (in_ready),
      .in_data        (in_data),
      .in_last        (in_last),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .H_matrix       (H_matrix),
      .signal_receive (signal_receive),
      .snr            (snr),
      .err_len        (err_len),
      .frame_cnt      (frame_cnt)
   );

   always #5 clk = ~clk;

   typedef logic [FW-1:0][31:0] frame_t;

   typedef struct {
      int len;
      bit useconst;
      int exp_frames;
      int exp_errs;
   } vec_t;

   int          tests = 0;
   int          fails = 0;
   frame_t      exp_q[$];
   logic [31:0] cur[$];
   bit          dropping = 0;
   bit          err_pend = 0;
   int          err_seen = 0;
   logic [15:0] exp_cnt = '0;
   bit          g_rand_ordy = 0;
   bit          g_ordy = 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] dut_word(input int i);
      if (i < NA * NA)      return H_matrix[i / NA][i % NA];
      else if (i < FW - 1)  return signal_receive[i - NA * NA];
      else                  return snr;
   endfunction

   task automatic check_frame(input frame_t f);
      int bad = -1;
      logic [31:0] a, e;
      a = '0;
      e = '0;
      for (int i = 0; i < FW; i++) begin
         if (dut_word(i) !== f[i] && bad < 0) begin
            bad = i;
            a = dut_word(i);
            e = f[i];
         end
      end
      tests++;
      if (bad >= 0) begin
         fails++;
         $display("FAIL frame_data word %0d: got %h expected %h", bad, a, e);
      end
   endtask

   // Frame rules: exactly FW words ending in in_last is a frame; in_last early
   // is an error; FW words without in_last is an error and the rest up to
   // in_last is thrown away.
   task automatic model_word(input logic [31:0] d, input bit l);
      frame_t f;
      if (dropping) begin
         if (l) dropping = 0;
      end else begin
         cur.push_back(d);
         if (l) begin
            if (cur.size() == FW) begin
               for (int i = 0; i < FW; i++) f[i] = cur[i];
               exp_q.push_back(f);
            end else begin
               err_pend = 1;
            end
            cur.delete();
         end else if (cur.size() == FW) begin
            err_pend = 1;
            dropping = 1;
            cur.delete();
         end
      end
   endtask

   task automatic step(input bit v, input logic [31:0] d, input bit l, input bit ordy, output bit acc);
      @(negedge clk);
      in_valid  = v;
      in_data   = d;
      in_last   = l;
      out_ready = ordy;
      acc = 0;
      if (!reset) begin
         chk("out_valid", 64'(out_valid), 64'(exp_q.size() != 0));
         chk("in_ready", 64'(in_ready), 64'(dropping || exp_q.size() < 2));
         chk("err_len", 64'(err_len), 64'(err_pend));
         chk("frame_cnt", 64'(frame_cnt), 64'(exp_cnt));
         if (err_len) err_seen++;
         err_pend = 0;
         if (out_valid && ordy && exp_q.size() != 0) begin
            check_frame(exp_q.pop_front());
            exp_cnt++;
         end
         if (v && in_ready) begin
            acc = 1;
            model_word(d, l);
         end
      end
   endtask

   function automatic bit ordy_now();
      if (g_rand_ordy) return ($urandom_range(3) != 0);
      return g_ordy;
   endfunction

   task automatic send_frame(input int len, input bit useconst, input int gap_pct);
      logic [31:0] w;
      bit acc, v;
      int tries;
      for (int i = 1; i <= len; i++) begin
         w = useconst ? 32'h3f800000 : $urandom;
         acc = 0;
         tries = 0;
         while (!acc) begin
            v = ($urandom_range(99) >= gap_pct);
            step(v, w, (i == len), ordy_now(), acc);
            tries++;
            if (tries > 500) begin
               tests++;
               fails++;
               $display("FAIL send_timeout: word %0d of %0d not accepted", i, len);
               return;
            end
         end
      end
   endtask

   task automatic idle(input int n);
      bit acc;
      for (int i = 0; i < n; i++) step(0, '0, 0, ordy_now(), acc);
   endtask

   task automatic drain();
      bit acc;
      for (int k = 0; k < 300; k++) begin
         if (exp_q.size() == 0) break;
         step(0, '0, 0, 1, acc);
      end
      step(0, '0, 0, 1, acc);
      chk("drain_empty", 64'(exp_q.size()), 64'd0);
   endtask

   task automatic do_reset(input int cycles, input bit offer);
      int nz = 0;
      @(negedge clk);
      reset     = 1;
      in_valid  = offer;
      in_data   = $urandom;
      in_last   = 0;
      out_ready = 0;
      repeat (cycles) @(negedge clk);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_in_ready", 64'(in_ready), 64'd0);
      chk("rst_err_len", 64'(err_len), 64'd0);
      chk("rst_frame_cnt", 64'(frame_cnt), 64'd0);
      for (int i = 0; i < FW; i++) if (dut_word(i) !== 32'd0) nz++;
      chk("rst_data_nonzero_words", 64'(nz), 64'd0);
      exp_q.delete();
      cur.delete();
      dropping = 0;
      err_pend = 0;
      exp_cnt  = '0;
      reset    = 0;
      in_valid = 0;
      #1;
      chk("in_ready_after_rst", 64'(in_ready), 64'd1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t tbl[7];
      logic [15:0] c0;
      int e0, nacc;
      bit acc;

      tbl[0] = '{FW,     1, 1, 0};
      tbl[1] = '{10,     0, 0, 1};
      tbl[2] = '{FW + 4, 0, 0, 1};
      tbl[3] = '{FW,     0, 1, 0};
      tbl[4] = '{1,      0, 0, 1};
      tbl[5] = '{FW + 1, 0, 0, 1};
      tbl[6] = '{FW,     0, 1, 0};

      reset = 1; in_valid = 0; in_data = '0; in_last = 0; out_ready = 0;
      do_reset(3, 0);

      // Table vectors with the consumer always ready.
      g_rand_ordy = 0;
      g_ordy = 1;
      for (int t = 0; t < 7; t++) begin
         c0 = frame_cnt;
         e0 = err_seen;
         send_frame(tbl[t].len, tbl[t].useconst, 0);
         idle(3);
         chk($sformatf("tbl%0d_frames", t), 64'(frame_cnt - c0), 64'(tbl[t].exp_frames));
         chk($sformatf("tbl%0d_errs", t), 64'(err_seen - e0), 64'(tbl[t].exp_errs));
      end

      // Back-pressure: two frames fill both banks, third is held off.
      g_ordy = 0;
      c0 = frame_cnt;
      send_frame(FW, 0, 0);
      send_frame(FW, 0, 0);
      nacc = 0;
      for (int i = 0; i < 5; i++) begin
         step(1, $urandom, 0, 0, acc);
         if (acc) nacc++;
      end
      chk("held_off_accepts", 64'(nacc), 64'd0);
      g_ordy = 1;
      send_frame(FW, 0, 0);
      drain();
      chk("backpressure_frames", 64'(frame_cnt - c0), 64'd3);

      // Release of one frame on the same edge the next one completes.
      g_ordy = 0;
      c0 = frame_cnt;
      send_frame(FW, 0, 0);
      for (int i = 1; i <= FW; i++) step(1, $urandom, (i == FW), (i == FW), acc);
      drain();
      chk("simul_frames", 64'(frame_cnt - c0), 64'd2);

      // Reset during a partial frame, then a clean frame.
      g_ordy = 1;
      for (int i = 0; i < 7; i++) step(1, $urandom, 0, 1, acc);
      do_reset(2, 1);
      send_frame(FW, 0, 0);
      drain();
      chk("post_rst_frame_cnt", 64'(frame_cnt), 64'd1);

      // Randomized traffic, gaps and consumer stalls.
      g_rand_ordy = 1;
      for (int f = 0; f < 40; f++) begin
         send_frame(($urandom_range(9) == 0) ? int'($urandom_range(27, 1)) : FW, 0, 25);
      end
      g_rand_ordy = 0;
      drain();
      idle(2);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
